// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter sharing a single-port on-chip RAM, with grant/contention counters.
// Round-robin or fixed m0 priority; reads return one cycle after acceptance.
module onchip_mem_arbiter #(
  parameter int AW             = 14,
  parameter int DW             = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [AW-1:0]     m0_address,
  input  logic [DW/8-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DW-1:0]     m0_writedata,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [AW-1:0]     m1_address,
  input  logic [DW/8-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DW-1:0]     m1_writedata,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdatavalid,

  output logic [AW-1:0]     mem_address,
  output logic [DW/8-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DW-1:0]     mem_writedata,
  output logic              mem_clken,
  input  logic [DW-1:0]     mem_readdata,

  input  logic              clr_counters,
  output logic [CNT_W-1:0]  grant_count0,
  output logic [CNT_W-1:0]  grant_count1,
  output logic [CNT_W-1:0]  conflict_count
);

  logic req0, req1;
  logic gnt0, gnt1;
  logic prio;      // 0: m0 wins next contention, 1: m1 wins
  logic rd_v;
  logic rd_owner;

  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (req0 && req1) begin
        if ((FIXED_PRIORITY != 0) || !prio) gnt0 = 1'b1;
        else                                gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = 1'b0;
    if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end else if (gnt0) begin
      mem_write      = m0_write;
    end
  end

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_clken      = reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio     <= 1'b0;
      rd_v     <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      if (gnt0)      prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;
      rd_v     <= (gnt0 & ~m0_write) | (gnt1 & ~m1_write);
      rd_owner <= gnt1;
    end
  end

  // Gated by reset_n so a read captured just before reset asserts never reports valid data.
  assign m0_readdatavalid = rd_v & ~rd_owner & reset_n;
  assign m1_readdatavalid = rd_v &  rd_owner & reset_n;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n || clr_counters) begin
      grant_count0   <= '0;
      grant_count1   <= '0;
      conflict_count <= '0;
    end else begin
      if (gnt0)          grant_count0   <= grant_count0 + CNT_W'(1);
      if (gnt1)          grant_count1   <= grant_count1 + CNT_W'(1);
      if (req0 && req1)  conflict_count <= conflict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboarded bench for onchip_mem_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same request stimulus, each with its own RAM model.
module tb_onchip_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clr_counters;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;

  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [CW-1:0] grant_count0, grant_count1, conflict_count;

  logic          f_m0_waitrequest, f_m1_waitrequest, f_m0_readdatavalid, f_m1_readdatavalid;
  logic [DW-1:0] f_m0_readdata, f_m1_readdata;
  logic [AW-1:0] f_mem_address;
  logic [BW-1:0] f_mem_byteenable;
  logic          f_mem_chipselect, f_mem_write, f_mem_clken;
  logic [DW-1:0] f_mem_writedata, f_mem_readdata;
  logic [CW-1:0] f_grant_count0, f_grant_count1, f_conflict_count;

  onchip_mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIORITY(0), .CNT_W(CW)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .clr_counters(clr_counters), .grant_count0(grant_count0), .grant_count1(grant_count1),
    .conflict_count(conflict_count)
  );

  onchip_mem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIORITY(1), .CNT_W(CW)) u_fix (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(f_m0_waitrequest),
    .m0_readdata(f_m0_readdata), .m0_readdatavalid(f_m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(f_m1_waitrequest),
    .m1_readdata(f_m1_readdata), .m1_readdatavalid(f_m1_readdatavalid),
    .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
    .mem_chipselect(f_mem_chipselect), .mem_write(f_mem_write), .mem_writedata(f_mem_writedata),
    .mem_clken(f_mem_clken), .mem_readdata(f_mem_readdata),
    .clr_counters(clr_counters), .grant_count0(f_grant_count0), .grant_count1(f_grant_count1),
    .conflict_count(f_conflict_count)
  );

  // RAM models: registered address, unregistered read data, byte-lane writes.
  logic [DW-1:0] ram  [DEPTH];
  logic [DW-1:0] fram [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [AW-1:0] ra, fra;

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    return 32'h1000_0000 ^ (i * 32'h0000_9E37);
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = init_word(i);
      fram[i]   = init_word(i);
      shadow[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (mem_clken) begin
      ra <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    if (f_mem_clken) begin
      fra <= f_mem_address;
      if (f_mem_chipselect && f_mem_write)
        for (int b = 0; b < BW; b++)
          if (f_mem_byteenable[b]) fram[f_mem_address][8*b +: 8] <= f_mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata   = ram[ra];
  assign f_mem_readdata = fram[fra];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard for the round-robin instance: push on acceptance, pop on readdatavalid.
  logic [DW-1:0] q0[$], q1[$];

  task automatic shadow_write(input logic [AW-1:0] a, input logic [BW-1:0] be,
                              input logic [DW-1:0] d);
    for (int b = 0; b < BW; b++)
      if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
  endtask

  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      if (q0.size() == 0) chk("m0_rdv_unexpected", 1, 0);
      else chk("m0_rdata", m0_readdata, q0.pop_front());
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) chk("m1_rdv_unexpected", 1, 0);
      else chk("m1_rdata", m1_readdata, q1.pop_front());
    end
    if (reset_n) begin
      if (!m0_waitrequest) begin
        if (m0_write) shadow_write(m0_address, m0_byteenable, m0_writedata);
        else          q0.push_back(shadow[m0_address]);
      end
      if (!m1_waitrequest) begin
        if (m1_write) shadow_write(m1_address, m1_byteenable, m1_writedata);
        else          q1.push_back(shadow[m1_address]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned n0, n1, c;

  initial begin
    reset_n = 1'b0; clr_counters = 1'b0;
    m0_address = 14'h100; m1_address = 14'h200;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_read = 1'b1; m1_read = 1'b1; m0_write = 1'b0; m1_write = 1'b0;
    m0_writedata = '0; m1_writedata = '0;
    #1;

    // Reset with both requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_wait0", m0_waitrequest, 1);
      chk("rst_wait1", m1_waitrequest, 1);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_wr", mem_write, 0);
      chk("rst_clken", mem_clken, 0);
      next_cycle();
    end
    chk("rst_gc0", grant_count0, 0);
    chk("rst_gc1", grant_count1, 0);
    chk("rst_cc", conflict_count, 0);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);

    // Continuous contention: 8 reads each, alternating grants starting with m0
    reset_n = 1'b1;
    n0 = 0; n1 = 0; c = 0;
    while ((n0 < 8 || n1 < 8) && c < 40) begin
      m0_read = (n0 < 8); m0_address = 14'h100 + AW'(n0);
      m1_read = (n1 < 8); m1_address = 14'h200 + AW'(n1);
      @(negedge clk);
      if (c == 0) chk("clken_on", mem_clken, 1);
      if (m0_read && m1_read) begin
        chk("rr_gnt0", !m0_waitrequest, (c % 2) == 0);
        chk("rr_gnt1", !m1_waitrequest, (c % 2) == 1);
      end else begin
        chk("solo_gnt0", !m0_waitrequest, m0_read);
        chk("solo_gnt1", !m1_waitrequest, m1_read);
      end
      if (m0_read && !m0_waitrequest) n0++;
      if (m1_read && !m1_waitrequest) n1++;
      c++;
      next_cycle();
    end
    chk("rr_cycles", c, 16);
    m0_read = 1'b0; m1_read = 1'b0;
    chk("rr_gc0", grant_count0, 8);
    chk("rr_gc1", grant_count1, 8);
    chk("rr_cc", conflict_count, 15);

    // m0 write then read back
    m0_write = 1'b1; m0_address = 14'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    @(negedge clk);
    chk("wr_wait", m0_waitrequest, 0);
    chk("wr_cs", mem_chipselect, 1);
    chk("wr_we", mem_write, 1);
    chk("wr_addr", mem_address, 14'h0010);
    next_cycle();
    m0_write = 1'b0; m0_read = 1'b1;
    @(negedge clk);
    chk("rd_wait", m0_waitrequest, 0);
    chk("rd_rdv_early", m0_readdatavalid, 0);
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    chk("rd_rdv0", m0_readdatavalid, 1);
    chk("rd_data0", m0_readdata, 32'hDEADBEEF);
    chk("rd_rdv1", m1_readdatavalid, 0);
    chk("idle_cs", mem_chipselect, 0);
    next_cycle();

    // Fixed priority: m1 starved while m0 requests, granted once m0 idles
    m0_read = 1'b1; m0_address = 14'h300;
    m1_read = 1'b1; m1_address = 14'h301;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fix_gnt0", f_m0_waitrequest, 0);
      chk("fix_stall1", f_m1_waitrequest, 1);
      next_cycle();
    end
    m0_read = 1'b0;
    @(negedge clk);
    chk("fix_gnt1", f_m1_waitrequest, 0);
    next_cycle();
    m1_read = 1'b0;

    // Byte lanes; read+write together counts as a write
    m0_write = 1'b1; m0_address = 14'h0020; m0_writedata = 32'hFFFFFFFF; m0_byteenable = 4'hF;
    @(negedge clk);
    chk("bl_wait0", m0_waitrequest, 0);
    next_cycle();
    m0_write = 1'b0;
    m1_write = 1'b1; m1_read = 1'b1; m1_address = 14'h0020;
    m1_writedata = 32'h00000000; m1_byteenable = 4'h5;
    @(negedge clk);
    chk("bl_wait1", m1_waitrequest, 0);
    chk("bl_we", mem_write, 1);
    chk("bl_be", mem_byteenable, 4'h5);
    next_cycle();
    m1_write = 1'b0; m1_byteenable = 4'hF;
    @(negedge clk);
    chk("bl_rd_wait", m1_waitrequest, 0);
    next_cycle();
    m1_read = 1'b0;
    @(negedge clk);
    chk("bl_rdv", m1_readdatavalid, 1);
    chk("bl_data", m1_readdata, 32'hFF00FF00);
    next_cycle();

    // Reset right after an accepted m1 read: no valid pulse
    m1_read = 1'b1; m1_address = 14'h0040;
    @(negedge clk);
    chk("rr_rd_wait", m1_waitrequest, 0);
    next_cycle();
    m1_read = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    chk("rst_no_rdv_a", m1_readdatavalid, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_no_rdv_b", m1_readdatavalid, 0);
    chk("rd_dropped", q1.size(), 1);
    q1.delete();
    chk("rst_gc1_mid", grant_count1, 0);
    next_cycle();

    // Clear wins over increment
    reset_n = 1'b1;
    m0_write = 1'b1; m0_address = 14'h0050; m0_writedata = 32'h12345678; clr_counters = 1'b1;
    @(negedge clk);
    chk("clr_wait", m0_waitrequest, 0);
    next_cycle();
    m0_write = 1'b0; clr_counters = 1'b0;
    @(negedge clk);
    chk("clr_vs_inc", grant_count0, 0);
    next_cycle();
    m0_read = 1'b1;
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    chk("inc_after_clr", grant_count0, 1);
    next_cycle();
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
